alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 182 ++++++++++++++++++
 tb/tb_alu_mc.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
`timescale 1ns/1ps
// alu_mc: multi-cycle ALU with registered result strobe.
// Single-cycle opcodes complete on the accept edge; opcode 0011 runs an
// iterative restoring divider when ALU_MC_DIV_EN is defined, otherwise it
// reports an error like opcode 1111.
module alu_mc #(
   parameter int DATA_W = 8,
   parameter int OUT_W  = 2*DATA_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [3:0]        ALU_FUN,
   input  logic              IN_VALID,
   output logic              IN_READY,
   output logic [OUT_W-1:0]  ALU_OUT,
   output logic              OUT_VALID,
   output logic              ERR
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_NAND = 4'b0110;
   localparam logic [3:0] OP_NOR  = 4'b0111;
   localparam logic [3:0] OP_XOR  = 4'b1000;
   localparam logic [3:0] OP_XNOR = 4'b1001;
   localparam logic [3:0] OP_EQ   = 4'b1010;
   localparam logic [3:0] OP_GT   = 4'b1011;
   localparam logic [3:0] OP_LT   = 4'b1100;
   localparam logic [3:0] OP_SHR  = 4'b1101;
   localparam logic [3:0] OP_SHL  = 4'b1110;

   logic [OUT_W-1:0]  a_ext;
   logic [OUT_W-1:0]  b_ext;
   logic [OUT_W-1:0]  res;
   logic [DATA_W-1:0] lres;
   logic              res_err;
   logic              accept;
   logic              start_div;
   logic              div_done;
   logic [OUT_W-1:0]  div_res;

   assign a_ext  = OUT_W'(A);
   assign b_ext  = OUT_W'(B);
   assign accept = IN_VALID & IN_READY;

   // Single-cycle result for the opcode currently on the inputs
   always_comb begin
      res     = '0;
      lres    = '0;
      res_err = 1'b0;
      case (ALU_FUN)
         OP_ADD:  res = a_ext + b_ext;
         OP_SUB:  res = a_ext - b_ext;
         OP_MUL:  res = a_ext * b_ext;
         OP_DIV: begin
`ifdef ALU_MC_DIV_EN
            // Only strobed when B==0; nonzero divisors go to the divider
            res = OUT_W'({A, {DATA_W{1'b1}}});
`endif
            res_err = 1'b1;
         end
         OP_AND:  begin lres = A & B;    res = OUT_W'(lres); end
         OP_OR:   begin lres = A | B;    res = OUT_W'(lres); end
         OP_NAND: begin lres = ~(A & B); res = OUT_W'(lres); end
         OP_NOR:  begin lres = ~(A | B); res = OUT_W'(lres); end
         OP_XOR:  begin lres = A ^ B;    res = OUT_W'(lres); end
         OP_XNOR: begin lres = ~(A ^ B); res = OUT_W'(lres); end
         OP_EQ:   res = (A == B) ? OUT_W'(1) : '0;
         OP_GT:   res = (A > B)  ? OUT_W'(2) : '0;
         OP_LT:   res = (A < B)  ? OUT_W'(3) : '0;
         OP_SHR:  begin lres = A >> 1; res = OUT_W'(lres); end
         OP_SHL:  res = OUT_W'({A, 1'b0});
         default: begin
            res     = '0;
            res_err = 1'b1;
         end
      endcase
   end

`ifdef ALU_MC_DIV_EN
   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rem;
   logic [DATA_W-1:0] quo;
   logic [DATA_W-1:0] dvs;
   logic [DATA_W-1:0] rem_nxt;
   logic [DATA_W-1:0] quo_nxt;
   logic [DATA_W:0]   shifted;
   logic [DATA_W:0]   trial;

   assign IN_READY  = (state == IDLE);
   assign start_div = accept && (ALU_FUN == OP_DIV) && (B != '0);
   assign div_done  = (state == DONE);
   assign div_res   = OUT_W'({rem, quo});

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_div) state_nxt = DIV;
         DIV:     if (cnt == CNT_W'(DATA_W-1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // One restoring-division step: quotient shifts left, next dividend bit enters remainder
   always_comb begin
      shifted = {rem, quo[DATA_W-1]};
      trial   = shifted - {1'b0, dvs};
      if (trial[DATA_W]) begin
         rem_nxt = shifted[DATA_W-1:0];
         quo_nxt = {quo[DATA_W-2:0], 1'b0};
      end else begin
         rem_nxt = trial[DATA_W-1:0];
         quo_nxt = {quo[DATA_W-2:0], 1'b1};
      end
   end

   // Divider registers: load on accept, iterate while in DIV
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rem <= '0;
         quo <= '0;
         dvs <= '0;
         cnt <= '0;
      end else if (start_div) begin
         rem <= '0;
         quo <= A;
         dvs <= B;
         cnt <= '0;
      end else if (state == DIV) begin
         rem <= rem_nxt;
         quo <= quo_nxt;
         cnt <= cnt + CNT_W'(1);
      end
   end
`else
   assign IN_READY  = 1'b1;
   assign start_div = 1'b0;
   assign div_done  = 1'b0;
   assign div_res   = '0;
`endif

   // Result register: strobe for one cycle, hold ALU_OUT between strobes
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ALU_OUT   <= '0;
         OUT_VALID <= 1'b0;
         ERR       <= 1'b0;
      end else begin
         OUT_VALID <= 1'b0;
         ERR       <= 1'b0;
         if (div_done) begin
            ALU_OUT   <= div_res;
            OUT_VALID <= 1'b1;
         end else if (accept && !start_div) begin
            ALU_OUT   <= res;
            ERR       <= res_err;
            OUT_VALID <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
`timescale 1ns/1ps
// tb_alu_mc: scoreboard bench for alu_mc (DATA_W=8). Expected results come
// from an arithmetic reference model; a negedge monitor pops and compares.
module tb_alu_mc;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [7:0]  A = '0;
   logic [7:0]  B = '0;
   logic [3:0]  ALU_FUN = '0;
   logic        IN_VALID = 1'b0;
   logic        IN_READY;
   logic [15:0] ALU_OUT;
   logic        OUT_VALID;
   logic        ERR;

   typedef struct packed {
      logic        err;
      logic [15:0] out;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] last_out = '0;
   logic [7:0]  ra, rb, rv;
   logic [3:0]  rop;
   int          lat;

   alu_mc #(.DATA_W(8), .OUT_W(16)) dut (
      .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .ALU_OUT(ALU_OUT),
      .OUT_VALID(OUT_VALID), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      int unsigned ai = a;
      int unsigned bi = b;
      int unsigned r  = 0;
      logic        e  = 1'b0;
      exp_t        m;
      case (op)
         4'd0:  r = ai + bi;
         4'd1:  r = (ai - bi) % 65536;
         4'd2:  r = ai * bi;
         4'd3: begin
`ifdef ALU_MC_DIV_EN
            if (bi == 0) begin r = ai * 256 + 255; e = 1'b1; end
            else r = (ai % bi) * 256 + ai / bi;
`else
            r = 0; e = 1'b1;
`endif
         end
         4'd4:  r = ai & bi;
         4'd5:  r = ai | bi;
         4'd6:  r = (~(ai & bi)) % 256;
         4'd7:  r = (~(ai | bi)) % 256;
         4'd8:  r = ai ^ bi;
         4'd9:  r = (~(ai ^ bi)) % 256;
         4'd10: r = (ai == bi) ? 1 : 0;
         4'd11: r = (ai > bi) ? 2 : 0;
         4'd12: r = (ai < bi) ? 3 : 0;
         4'd13: r = ai / 2;
         4'd14: r = ai * 2;
         default: begin r = 0; e = 1'b1; end
      endcase
      m.err = e;
      m.out = r[15:0];
      return m;
   endfunction

   function automatic bit is_long(input logic [7:0] b, input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
      return (op == 4'd3) && (b != 8'd0);
`else
      return (op == 4'd3) && (b == 8'd0) && (b != 8'd0);
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (IN_READY !== 1'b1 && n < 64) begin
         @(negedge CLK);
         n++;
      end
      if (IN_READY !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout actual=%0b required=1", IN_READY);
      end
   endtask

   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      wait_ready();
      A = a; B = b; ALU_FUN = op; IN_VALID = 1'b1;
      @(posedge CLK);
      q.push_back(model(a, b, op));
      #1;
      IN_VALID = 1'b0;
      A = 8'($urandom); B = 8'($urandom); ALU_FUN = 4'($urandom);
      if (!is_long(b, op)) begin
         @(negedge CLK);
         check("strobe_1cyc", 32'(OUT_VALID), 32'd1);
      end
   endtask

   // Monitor: every strobe pops the oldest expectation; quiet cycles must hold
   always @(negedge CLK) begin
      if (!RST) begin
         last_out = '0;
      end else if (OUT_VALID) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_strobe actual=%0h required=no_strobe", {ERR, ALU_OUT});
         end else begin
            mon_e = q.pop_front();
            check("result", 32'({ERR, ALU_OUT}), 32'(mon_e));
            last_out = mon_e.out;
         end
      end else begin
         check("idle_hold", 32'({ERR, ALU_OUT}), 32'({1'b0, last_out}));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge CLK);
      #1;
      check("reset_out",   32'(ALU_OUT),   32'd0);
      check("reset_valid", 32'(OUT_VALID), 32'd0);
      check("reset_err",   32'(ERR),       32'd0);
      RST = 1'b1;
      @(negedge CLK);
      check("ready_after_reset", 32'(IN_READY), 32'd1);

      issue(8'hFF, 8'h01, 4'd0);
      issue(8'h03, 8'h05, 4'd1);
      issue(8'hFF, 8'hFF, 4'd2);
      issue(8'h2A, 8'h00, 4'd3);

`ifdef ALU_MC_DIV_EN
      // 100/7: busy for 9 cycles, requests during busy are ignored
      wait_ready();
      A = 8'd100; B = 8'd7; ALU_FUN = 4'd3; IN_VALID = 1'b1;
      @(posedge CLK);
      q.push_back(model(8'd100, 8'd7, 4'd3));
      #1;
      ALU_FUN = 4'd0; A = 8'($urandom); B = 8'($urandom);
      lat = 0;
      @(negedge CLK);
      while (IN_READY !== 1'b1 && lat < 50) begin
         lat++;
         @(negedge CLK);
      end
      IN_VALID = 1'b0;
      check("div_busy_cycles", 32'(lat), 32'd9);
      check("div_strobe", 32'(OUT_VALID), 32'd1);
`endif

      // Back-to-back equality compares with IN_VALID held high
      wait_ready();
      for (int i = 0; i < 5; i++) begin
         rv = 8'($urandom);
         A = rv; B = rv; ALU_FUN = 4'd10; IN_VALID = 1'b1;
         @(posedge CLK);
         q.push_back(model(rv, rv, 4'd10));
         #1;
         if (i == 4) IN_VALID = 1'b0;
         @(negedge CLK);
         check("b2b_strobe", 32'(OUT_VALID), 32'd1);
      end

      // Reset in the middle of an operation
      wait_ready();
`ifdef ALU_MC_DIV_EN
      A = 8'hC3; B = 8'h05; ALU_FUN = 4'd3; IN_VALID = 1'b1;
      @(posedge CLK);
      q.push_back(model(8'hC3, 8'h05, 4'd3));
      #1;
      IN_VALID = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b0;
      void'(q.pop_back());
`else
      issue(8'hC3, 8'h05, 4'd2);
      @(posedge CLK);
      #1;
      RST = 1'b0;
`endif
      #1;
      check("midop_reset_out",   32'(ALU_OUT),   32'd0);
      check("midop_reset_valid", 32'(OUT_VALID), 32'd0);
      check("midop_reset_err",   32'(ERR),       32'd0);
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;
      @(negedge CLK);
      check("ready_after_midop_reset", 32'(IN_READY), 32'd1);
      issue(8'd1, 8'd2, 4'd0);

      // Randomized operations with frequent zero divisors and equal operands
      for (int i = 0; i < 300; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = 8'($urandom);
         rb  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         if ($urandom_range(0, 5) == 0) ra = rb;
         issue(ra, rb, rop);
      end

      wait_ready();
      repeat (3) @(negedge CLK);
      check("scoreboard_drain", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
